// File: rtl/regfile_write_arbiter.sv
// Register-file writeback arbiter. Several writeback requesters share one
// register-file write port under round-robin arbitration. The block also keeps
// a 32-entry scoreboard of outstanding destination writes and a saturating
// count of cycles in which requesters contended for the port.
`timescale 1ns/1ps
module regfile_write_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int DATA_W  = 32
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [5*NUM_REQ-1:0]      req_addr,
    input  logic [DATA_W*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      wr_enable,
    output logic [4:0]                wr_address,
    output logic [DATA_W-1:0]         wr_data,
    input  logic                      reserve_valid,
    input  logic [4:0]                reserve_addr,
    output logic [31:0]               pending,
    output logic [15:0]               conflict_count
);

    localparam logic [1:0] LAST_RST = 2'(NUM_REQ - 1);

    logic [1:0]         r_last_granted;
    logic               r_wr_enable;
    logic [4:0]         r_wr_address;
    logic [DATA_W-1:0]  r_wr_data;
    logic [31:0]        r_pending;
    logic [15:0]        r_conflict_count;

    logic [NUM_REQ-1:0] w_grant;
    logic [1:0]         w_grant_idx;
    logic               w_handshake;
    logic [4:0]         w_sel_addr;
    logic [DATA_W-1:0]  w_sel_data;
    logic               w_contended;
    logic [31:0]        w_pending_next;

    // Round-robin search starting just after the last granted requester.
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned, which is what keeps synthesis from inferring a latch.
    always_comb begin
        w_grant     = '0;
        w_grant_idx = r_last_granted;
        w_handshake = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            int idx;
            idx = (int'(r_last_granted) + k) % NUM_REQ;
            if (!w_handshake && req_valid[idx]) begin
                w_handshake = 1'b1;
                w_grant_idx = idx[1:0];
            end
        end
        if (w_handshake) begin
            w_grant[w_grant_idx] = 1'b1;
        end
    end

    // Grant is masked while reset is held so nothing is offered asynchronously.
    assign req_ready   = reset ? w_grant : '0;
    assign w_sel_addr  = req_addr[5*int'(w_grant_idx) +: 5];
    assign w_sel_data  = req_data[DATA_W*int'(w_grant_idx) +: DATA_W];
    assign w_contended = ($countones(req_valid) >= 2);

    // Scoreboard update: retire the write on the port, then apply a new
    // reservation so a same-edge reserve of the retiring register wins.
    always_comb begin
        w_pending_next = r_pending;
        if (r_wr_enable) begin
            w_pending_next[r_wr_address] = 1'b0;
        end
        if (reserve_valid && (reserve_addr != 5'd0)) begin
            w_pending_next[reserve_addr] = 1'b1;
        end
        w_pending_next[0] = 1'b0;
    end

    // Arbiter pointer moves only when a handshake actually happens.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_last_granted <= LAST_RST;
        end else if (w_handshake) begin
            r_last_granted <= w_grant_idx;
        end
    end

    // Registered write port: a granted write to r0 is swallowed, idle cycles
    // drop the enable and hold address/data.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wr_enable  <= 1'b0;
            r_wr_address <= '0;
            r_wr_data    <= '0;
        end else if (w_handshake && (w_sel_addr != 5'd0)) begin
            r_wr_enable  <= 1'b1;
            r_wr_address <= w_sel_addr;
            r_wr_data    <= w_sel_data;
        end else begin
            r_wr_enable  <= 1'b0;
        end
    end

    // Pending-write scoreboard register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_pending <= '0;
        end else begin
            r_pending <= w_pending_next;
        end
    end

    // Saturating count of cycles with two or more requesters valid.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_conflict_count <= '0;
        end else if (w_contended && (r_conflict_count != 16'hFFFF)) begin
            r_conflict_count <= r_conflict_count + 16'd1;
        end
    end

    assign wr_enable      = r_wr_enable;
    assign wr_address     = r_wr_address;
    assign wr_data        = r_wr_data;
    assign pending        = r_pending;
    assign conflict_count = r_conflict_count;

endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 3: number of writeback requesters (2..4).
REQ-002 Parameter DATA_W, default 32: write data width.
REQ-003 Port clock  in  1: single clock; all state updates on posedge clock.
REQ-004 Port reset  in  1: asynchronous, active-low reset.
REQ-005 Port req_valid  in  NUM_REQ: per-requester write request.
REQ-006 Port req_addr  in  5*NUM_REQ: destination register, requester i at bits [5i+4:5i].
REQ-007 Port req_data  in  DATA_W*NUM_REQ: write data, requester i at bits [DATA_W*i+DATA_W-1:DATA_W*i].
REQ-008 Port req_ready  out  NUM_REQ: grant; a handshake occurs when req_valid[i] and req_ready[i] are both high at posedge.
REQ-009 Port wr_enable  out  1: drives register file WriteEnable.
REQ-010 Port wr_address  out  5: drives register file write_address.
REQ-011 Port wr_data  out  DATA_W: drives register file write_data_in.
REQ-012 Port reserve_valid  in  1: decode reserves a destination register.
REQ-013 Port reserve_addr  in  5: register being reserved.
REQ-014 Port pending  out  32: scoreboard, bit a high = write to register a outstanding.
REQ-015 Port conflict_count  out  16: saturating count of contended cycles.

Function
REQ-016 The block SHALL assert at most one req_ready bit per cycle, and only to a requester with req_valid high.
REQ-017 Arbitration SHALL be round-robin: search starts at (last_granted+1) mod NUM_REQ, wrapping; last_granted resets to NUM_REQ-1 so requester 0 wins first.
REQ-018 last_granted SHALL update only on a handshake.
REQ-019 req_ready SHALL be combinational from req_valid and last_granted; the block SHALL grant every cycle at least one req_valid is high (no bubbles).
REQ-020 On handshake of requester i with req_addr≠0, the next cycle SHALL have wr_enable=1, wr_address=req_addr[i], wr_data=req_data[i] (latency 1 cycle, registered outputs).
REQ-021 Handshake with req_addr=0 SHALL be accepted but SHALL produce wr_enable=0 the next cycle.
REQ-022 Cycles without handshake SHALL produce wr_enable=0 the next cycle; wr_address/wr_data hold last value.
REQ-023 Requesters SHALL hold valid/addr/data stable until handshake; the block SHALL NOT buffer ungranted requests.
REQ-024 pending[a] SHALL set at posedge when reserve_valid=1, reserve_addr=a, a≠0.
REQ-025 pending[a] SHALL clear at the posedge where wr_enable=1 and wr_address=a.
REQ-026 Simultaneous set and clear of the same bit SHALL leave it set (new reservation wins).
REQ-027 Reserving an already-pending register SHALL leave it set; pending[0] SHALL always read 0.
REQ-028 A write to a non-pending register SHALL still be issued and SHALL leave pending unchanged.
REQ-029 conflict_count SHALL increment by 1 each cycle with two or more req_valid bits high, saturating at 16'hFFFF.

Reset
REQ-030 While reset is low: req_ready=0, wr_enable=0, wr_address=0, wr_data=0, pending=0, conflict_count=0, last_granted=NUM_REQ-1, asynchronously.
REQ-031 A write granted in the cycle reset asserts SHALL be discarded; wr_enable SHALL NOT pulse after reset release without a new handshake.
REQ-032 The first posedge after reset deassertion SHALL arbitrate normally.

Verification
REQ-033 Single requester: req_valid=001, addr 5, data 0xDEADBEEF -> req_ready=001 same cycle; next cycle wr_enable=1, wr_address=5, wr_data=0xDEADBEEF.
REQ-034 All three valid for 6 cycles -> grant order 0,1,2,0,1,2; conflict_count=6; wr_enable high cycles 2-7.
REQ-035 Requester 1 valid with addr 0 -> req_ready[1]=1; next cycle wr_enable=0.
REQ-036 Reserve addr 8, then write 8 via requester 2 -> pending[8]=1 until posedge after wr_enable with wr_address=8; same-edge reserve of 8 keeps pending[8]=1.
REQ-037 Force conflict_count to 0xFFFE, hold two valids 3 cycles -> 0xFFFF, stays 0xFFFF.
REQ-038 Assert reset low mid-burst with three valids -> all outputs 0 immediately; after release, requester 0 granted first, no stale write.
